bcid_reset_sequencer: RTL and testbench

Parametrised, timestamp-aligned generator of BCID-reset and chip-reset lines for NUM_CH front-end chips.
- Owns a free-running timestamp counter.
- Issues per-channel RESET_BCID pulses or levels, aligned to a programmable masked timestamp phase, in level, one-shot or periodic mode.
- Stretches per-channel chip reset (N_RST) to a guaranteed minimum length.
- Sits in the core next to the GPIO/config registers; drives chip pins directly and supplies TIMESTAMP to the RX and timestamp modules.

---
 rtl/bcid_reset_sequencer.sv | 166 ++++++++++++++++
 tb/tb_bcid_reset_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/bcid_reset_sequencer.sv
// bcid_reset_sequencer: free-running timestamp plus timestamp-aligned BCID-reset
// generator (LEVEL / ONESHOT / PERIODIC / OFF) and per-channel stretched chip reset.
// Optional build macro: BCID_PULSE_COUNT_EN enables the saturating PULSE_CNT counter;
// without it PULSE_CNT is tied to zero.

// Per-channel chip reset stretcher: N_RST stays low for at least RST_HOLD cycles
// after the request drops.
module bcid_nrst_hold #(
  parameter int RST_HOLD = 16
) (
  input  logic CLK,
  input  logic RST,
  input  logic RST_REQ,
  output logic N_RST
);
  localparam int HW = $clog2(RST_HOLD + 1);

  logic [HW-1:0] hold;

  // Reload while requested, count down after release; release on the cycle after hold reaches 1.
  always_ff @(posedge CLK) begin
    if (RST || RST_REQ) begin
      hold  <= HW'(RST_HOLD);
      N_RST <= 1'b0;
    end else begin
      if (hold != '0) hold <= hold - 1'b1;
      N_RST <= (hold <= HW'(1));
    end
  end
endmodule

module bcid_reset_sequencer #(
  parameter int NUM_CH     = 1,
  parameter int TS_WIDTH   = 64,
  parameter int ALIGN_BITS = 6,
  parameter int LEN_WIDTH  = 8,
  parameter int RST_HOLD   = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  TS_CLEAR,
  output logic [TS_WIDTH-1:0]   TIMESTAMP,
  input  logic [1:0]            MODE,
  input  logic [ALIGN_BITS-1:0] MATCH_VALUE,
  input  logic [ALIGN_BITS-1:0] MATCH_MASK,
  input  logic [LEN_WIDTH-1:0]  PULSE_LEN,
  input  logic [NUM_CH-1:0]     CH_EN,
  input  logic [NUM_CH-1:0]     LEVEL_IN,
  input  logic                  ARM,
  input  logic [NUM_CH-1:0]     RST_REQ,
  output logic [NUM_CH-1:0]     RESET_BCID,
  output logic [NUM_CH-1:0]     N_RST,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [15:0]           PULSE_CNT
);
  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_PULSE} state_t;

  localparam logic [1:0] M_LEVEL    = 2'd0;
  localparam logic [1:0] M_ONESHOT  = 2'd1;
  localparam logic [1:0] M_PERIODIC = 2'd2;
  localparam logic [1:0] M_OFF      = 2'd3;

  state_t               state, state_n;
  logic [1:0]           mode_q;
  logic [NUM_CH-1:0]    rb_n;
  logic [LEN_WIDTH-1:0] cnt, cnt_n, len_m1;
  logic                 done_n, start, match;

  assign match  = (((TIMESTAMP[ALIGN_BITS-1:0] ^ MATCH_VALUE) & MATCH_MASK) == '0);
  // Remaining-cycle count loaded at pulse entry; a zero length behaves as one cycle.
  assign len_m1 = (PULSE_LEN == '0) ? '0 : PULSE_LEN - 1'b1;

  // Next-state and output decode; a MODE change aborts everything silently for one cycle.
  always_comb begin
    state_n = state;
    rb_n    = RESET_BCID;
    cnt_n   = cnt;
    done_n  = 1'b0;
    start   = 1'b0;
    if (MODE != mode_q) begin
      state_n = S_IDLE;
      rb_n    = '0;
    end else begin
      case (MODE)
        M_LEVEL: begin
          state_n = S_IDLE;
          if (match) rb_n = LEVEL_IN & CH_EN;
        end
        M_ONESHOT, M_PERIODIC: begin
          case (state)
            S_IDLE: begin
              if (MODE == M_PERIODIC) begin
                if (match) start = 1'b1;
              end else if (ARM) begin
                state_n = S_ARMED;
              end
            end
            S_ARMED: if (match) start = 1'b1;
            S_PULSE: begin
              if (cnt == '0) begin
                state_n = S_IDLE;
                rb_n    = '0;
                done_n  = 1'b1;
              end else begin
                cnt_n = cnt - 1'b1;
              end
            end
            default: state_n = S_IDLE;
          endcase
        end
        default: begin
          state_n = S_IDLE;
          rb_n    = '0;
        end
      endcase
    end
    if (start) begin
      state_n = S_PULSE;
      rb_n    = CH_EN;
      cnt_n   = len_m1;
    end
  end

  // Timestamp, FSM state and all registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      TIMESTAMP  <= '0;
      state      <= S_IDLE;
      mode_q     <= M_OFF;
      RESET_BCID <= '0;
      cnt        <= '0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
    end else begin
      TIMESTAMP  <= TS_CLEAR ? '0 : TIMESTAMP + 1'b1;
      state      <= state_n;
      mode_q     <= MODE;
      RESET_BCID <= rb_n;
      cnt        <= cnt_n;
      BUSY       <= (state_n != S_IDLE);
      DONE       <= done_n;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    bcid_nrst_hold #(.RST_HOLD(RST_HOLD)) u_hold (
      .CLK     (CLK),
      .RST     (RST),
      .RST_REQ (RST_REQ[i]),
      .N_RST   (N_RST[i])
    );
  end

`ifdef BCID_PULSE_COUNT_EN
  logic [15:0] pcnt;
  // Saturating count of pulse starts, cleared together with the timestamp.
  always_ff @(posedge CLK) begin
    if (RST || TS_CLEAR)                pcnt <= '0;
    else if (start && pcnt != 16'hFFFF) pcnt <= pcnt + 1'b1;
  end
  assign PULSE_CNT = pcnt;
`else
  assign PULSE_CNT = '0;
`endif
endmodule

// File: tb/tb_bcid_reset_sequencer.sv
// Directed bench: stimulus pushes expected output-change events (timestamp plus
// {RESET_BCID, N_RST, BUSY, DONE}); a monitor pops and compares on every observed change.
module tb_bcid_reset_sequencer;
  localparam int NUM_CH = 2, TS_WIDTH = 64, ALIGN_BITS = 6, LEN_WIDTH = 8, RST_HOLD = 16;
`ifdef BCID_PULSE_COUNT_EN
  localparam bit PC_EN = 1'b1;
`else
  localparam bit PC_EN = 1'b0;
`endif

  logic                  CLK = 1'b0;
  logic                  RST, TS_CLEAR, ARM;
  logic [TS_WIDTH-1:0]   TIMESTAMP;
  logic [1:0]            MODE;
  logic [ALIGN_BITS-1:0] MATCH_VALUE, MATCH_MASK;
  logic [LEN_WIDTH-1:0]  PULSE_LEN;
  logic [NUM_CH-1:0]     CH_EN, LEVEL_IN, RST_REQ, RESET_BCID, N_RST;
  logic                  BUSY, DONE;
  logic [15:0]           PULSE_CNT;

  bcid_reset_sequencer #(
    .NUM_CH(NUM_CH), .TS_WIDTH(TS_WIDTH), .ALIGN_BITS(ALIGN_BITS),
    .LEN_WIDTH(LEN_WIDTH), .RST_HOLD(RST_HOLD)
  ) dut (
    .CLK(CLK), .RST(RST), .TS_CLEAR(TS_CLEAR), .TIMESTAMP(TIMESTAMP), .MODE(MODE),
    .MATCH_VALUE(MATCH_VALUE), .MATCH_MASK(MATCH_MASK), .PULSE_LEN(PULSE_LEN),
    .CH_EN(CH_EN), .LEVEL_IN(LEVEL_IN), .ARM(ARM), .RST_REQ(RST_REQ),
    .RESET_BCID(RESET_BCID), .N_RST(N_RST), .BUSY(BUSY), .DONE(DONE), .PULSE_CNT(PULSE_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [63:0] ts;
    logic [5:0]  obs;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        mon_e;
  int         n_chk = 0;
  int         n_fail = 0;
  bit         mon_en = 1'b0;
  logic [5:0] prev = '0;
  logic [5:0] cur;

  task automatic push(input logic [63:0] t, input logic [1:0] rb, input logic [1:0] nr,
                      input logic b, input logic d);
    ev_t e;
    e.ts  = t;
    e.obs = {rb, nr, b, d};
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [63:0] pc(input int n);
    return PC_EN ? 64'(n) : 64'd0;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_ts(input logic [63:0] v);
    int n;
    n = 0;
    while (TIMESTAMP != v && n < 400) begin
      @(posedge CLK);
      #1;
      n++;
    end
    if (TIMESTAMP != v) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_ts: timestamp %0h, expected to reach %0h", TIMESTAMP, v);
    end
  endtask

  // Monitor: every change of the observed output vector must match the next expected event.
  always @(negedge CLK) begin
    cur = {RESET_BCID, N_RST, BUSY, DONE};
    if (mon_en && cur != prev) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: ts=%0h obs=%b, expected no change", TIMESTAMP, cur);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.ts != TIMESTAMP || mon_e.obs != cur) begin
          n_fail++;
          $display("FAIL event: ts=%0h obs=%b, expected ts=%0h obs=%b",
                   TIMESTAMP, cur, mon_e.ts, mon_e.obs);
        end
      end
    end
    prev = cur;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; TS_CLEAR = 1'b0; ARM = 1'b0; MODE = 2'd3;
    MATCH_VALUE = '0; MATCH_MASK = '0; PULSE_LEN = '0;
    CH_EN = 2'b11; LEVEL_IN = '0; RST_REQ = '0;

    // Reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_ts", TIMESTAMP, 0);
    chk("rst_bcid", RESET_BCID, 0);
    chk("rst_nrst", N_RST, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_pcnt", PULSE_CNT, 0);
    RST = 1'b0;
    mon_en = 1'b1;
    push(64'h10, 2'b00, 2'b11, 1'b0, 1'b0);
    @(negedge CLK); chk("ts_1", TIMESTAMP, 1);
    @(negedge CLK); chk("ts_2", TIMESTAMP, 2);
    @(negedge CLK); chk("ts_3", TIMESTAMP, 3);

    // LEVEL mode
    MODE = 2'd0; MATCH_MASK = 6'h3F; MATCH_VALUE = 6'h30; LEVEL_IN = 2'b01;
    push(64'h31, 2'b01, 2'b11, 1'b0, 1'b0);
    push(64'h71, 2'b00, 2'b11, 1'b0, 1'b0);
    wait_ts(64'h35);
    LEVEL_IN = 2'b00;

    // ONESHOT, with timestamp rewound
    wait_ts(64'h72);
    MODE = 2'd1; MATCH_VALUE = 6'h10; PULSE_LEN = 8'd4; TS_CLEAR = 1'b1;
    push(64'h06, 2'b00, 2'b11, 1'b1, 1'b0);
    push(64'h11, 2'b11, 2'b11, 1'b1, 1'b0);
    push(64'h15, 2'b00, 2'b11, 1'b0, 1'b1);
    push(64'h16, 2'b00, 2'b11, 1'b0, 1'b0);
    step();
    TS_CLEAR = 1'b0;
    @(negedge CLK); chk("ts_clear", TIMESTAMP, 0);
    wait_ts(64'h05);
    ARM = 1'b1;
    step();
    ARM = 1'b0;
    wait_ts(64'h12);
    PULSE_LEN = 8'd9; CH_EN = 2'b01;   // must not affect the running pulse
    wait_ts(64'h18);
    chk("pcnt_oneshot", PULSE_CNT, pc(1));

    // PERIODIC, 1-cycle pulses
    CH_EN = 2'b11; MODE = 2'd2; MATCH_MASK = 6'h0F; MATCH_VALUE = 6'h00; PULSE_LEN = 8'd0;
    push(64'h21, 2'b11, 2'b11, 1'b1, 1'b0);
    push(64'h22, 2'b00, 2'b11, 1'b0, 1'b1);
    push(64'h23, 2'b00, 2'b11, 1'b0, 1'b0);
    push(64'h31, 2'b11, 2'b11, 1'b1, 1'b0);
    push(64'h32, 2'b00, 2'b11, 1'b0, 1'b1);
    push(64'h33, 2'b00, 2'b11, 1'b0, 1'b0);
    wait_ts(64'h34);
    chk("pcnt_periodic1", PULSE_CNT, pc(3));

    // PERIODIC, 20-cycle pulses: every second match ignored
    PULSE_LEN = 8'd20;
    push(64'h41, 2'b11, 2'b11, 1'b1, 1'b0);
    push(64'h55, 2'b00, 2'b11, 1'b0, 1'b1);
    push(64'h56, 2'b00, 2'b11, 1'b0, 1'b0);
    push(64'h61, 2'b11, 2'b11, 1'b1, 1'b0);
    push(64'h75, 2'b00, 2'b11, 1'b0, 1'b1);
    push(64'h76, 2'b00, 2'b11, 1'b0, 1'b0);
    wait_ts(64'h77);
    chk("pcnt_periodic20", PULSE_CNT, pc(5));
    MODE = 2'd3;

    // One-cycle chip reset request on channel 0
    wait_ts(64'h78);
    RST_REQ = 2'b01;
    push(64'h79, 2'b00, 2'b10, 1'b0, 1'b0);
    push(64'h89, 2'b00, 2'b11, 1'b0, 1'b0);
    step();
    RST_REQ = 2'b00;

    // ONESHOT aborted mid-pulse by MODE=OFF together with TS_CLEAR
    wait_ts(64'h8A);
    MODE = 2'd1; MATCH_MASK = 6'h3F; MATCH_VALUE = 6'h10; PULSE_LEN = 8'd8;
    push(64'h8C, 2'b00, 2'b11, 1'b1, 1'b0);
    push(64'h91, 2'b11, 2'b11, 1'b1, 1'b0);
    wait_ts(64'h8B);
    ARM = 1'b1;
    step();
    ARM = 1'b0;
    wait_ts(64'h93);
    chk("pcnt_abort_before", PULSE_CNT, pc(6));
    MODE = 2'd3; TS_CLEAR = 1'b1;
    push(64'h00, 2'b00, 2'b11, 1'b0, 1'b0);
    step();
    TS_CLEAR = 1'b0;
    @(negedge CLK);
    chk("abort_ts", TIMESTAMP, 0);
    chk("abort_pcnt", PULSE_CNT, 0);
    chk("abort_busy", BUSY, 0);
    chk("abort_bcid", RESET_BCID, 0);
    chk("abort_done", DONE, 0);

    repeat (30) @(negedge CLK);
    chk("events_pending", 64'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
